adc_poll_seq: RTL and testbench

Periodic polling sequencer that sits directly upstream of the ADC wrapper and acts as the master on its APB/DRP port. Once per sample period it:
- pulses CONVST,
- waits a fixed conversion time,
- reads a fixed list of ADC result registers over APB,
- emits each result as a one-cycle-valid stream to downstream logic (DMA/monitor).

It is read-only on the APB side; it never writes the ADC.

---
 rtl/adc_poll_seq.sv | 204 ++++++++++++++++++++
 tb/tb_adc_poll_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_poll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adc_poll_seq
//  Purpose  : Periodic ADC polling sequencer. Once per sample period it pulses
//             CONVST, waits out the conversion time, then reads a fixed list
//             of result registers over a read-only APB master port and
//             streams each result downstream as a one-cycle strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_poll_seq #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned CONV_WAIT     = 64,
    parameter int unsigned NUM_CH        = 4,
    parameter logic [31:0] CH_ADDR       = 32'h13_12_01_00,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        convst,
    output logic [7:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic [15:0] prdata,
    input  logic        pready,
    output logic [15:0] sample_data,
    output logic [1:0]  sample_idx,
    output logic        sample_valid,
    output logic        frame_done,
    output logic        timeout_err,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned        c_PCNT_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]         c_WAIT_LAST = 8'(CONV_WAIT - 1);
    localparam logic [7:0]         c_TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [1:0]         c_IDX_LAST  = 2'(NUM_CH - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CONV   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_SETUP  = 3'd3;
    localparam logic [2:0] c_ST_ACCESS = 3'd4;
    localparam logic [2:0] c_ST_NEXT   = 3'd5;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic [7:0]          r_wcnt;
    logic [7:0]          r_tcnt;
    logic [1:0]          r_idx;
    logic                r_ok;
    logic [15:0]         r_capture;
    logic                r_timeout_err;
    logic                w_frame_start;
    logic                w_access_hit;
    logic                w_access_tmo;
    logic [7:0]          w_addr_tbl [0:3];

    // Unpack the per-channel register addresses into a small lookup table
    generate
        for (genvar g = 0; g < 4; g++) begin : g_addr
            assign w_addr_tbl[g] = CH_ADDR[8*g +: 8];
        end
    endgenerate

    // A frame is launched only from IDLE on the counter's zero phase; a frame
    // still running at the wrap simply swallows that start.
    assign w_frame_start = enable && (r_pcnt == '0) && (r_state == c_ST_IDLE);
    assign w_access_hit  = (r_state == c_ST_ACCESS) && pready;
    assign w_access_tmo  = (r_state == c_ST_ACCESS) && !pready && (r_tcnt == c_TO_LAST);

    // Period counter: free-runs while enabled, parked at zero otherwise so a
    // re-enable launches a frame on the very first enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!enable) begin
            r_pcnt <= '0;
        end else if (r_pcnt == c_PCNT_LAST) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_frame_start) begin
                    w_state_nxt = c_ST_CONV;
                end
            end
            c_ST_CONV: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (r_wcnt == c_WAIT_LAST) begin
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_state_nxt = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                if (w_access_hit || w_access_tmo) begin
                    w_state_nxt = c_ST_NEXT;
                end
            end
            c_ST_NEXT: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_SETUP;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Conversion-wait and access-timeout counters, restarted on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= 8'h00;
            r_tcnt <= 8'h00;
        end else begin
            if (r_state == c_ST_CONV) begin
                r_wcnt <= 8'h00;
            end else if (r_state == c_ST_WAIT) begin
                r_wcnt <= r_wcnt + 8'h01;
            end
            if (r_state == c_ST_SETUP) begin
                r_tcnt <= 8'h00;
            end else if ((r_state == c_ST_ACCESS) && !pready) begin
                r_tcnt <= r_tcnt + 8'h01;
            end
        end
    end

    // Channel index, read capture and the sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= 2'd0;
            r_ok          <= 1'b0;
            r_capture     <= 16'h0000;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_ST_CONV) begin
                r_idx <= 2'd0;
            end else if ((r_state == c_ST_NEXT) && (r_idx != c_IDX_LAST)) begin
                r_idx <= r_idx + 2'd1;
            end
            // r_ok marks that the current channel completed with data
            if (r_state == c_ST_SETUP) begin
                r_ok <= 1'b0;
            end else if (w_access_hit) begin
                r_ok      <= 1'b1;
                r_capture <= prdata;
            end
            if (w_access_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded straight from registered state so an async reset
    // clears the bus and strobes immediately.
    // ------------------------------------------------------------------------
    assign convst       = (r_state == c_ST_CONV);
    assign psel         = (r_state == c_ST_SETUP) || (r_state == c_ST_ACCESS);
    assign penable      = (r_state == c_ST_ACCESS);
    assign pwrite       = 1'b0;
    assign paddr        = psel ? w_addr_tbl[r_idx] : 8'h00;
    assign sample_valid = (r_state == c_ST_NEXT) && r_ok;
    assign frame_done   = (r_state == c_ST_NEXT) && (r_idx == c_IDX_LAST);
    assign sample_data  = r_capture;
    assign sample_idx   = r_idx;
    assign timeout_err  = r_timeout_err;
    assign busy         = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_poll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_poll_seq
//  Purpose  : Self-checking bench for adc_poll_seq. Each launched frame is
//             expanded into a per-cycle expected schedule table (convst,
//             wait, setup/access/next per channel) from the timing rules; the
//             bench plays the APB slave from that same schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_poll_seq;

    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam int unsigned CONV_WAIT     = 64;
    localparam int unsigned NUM_CH        = 4;
    localparam logic [31:0] CH_ADDR       = 32'h13_12_01_00;
    localparam int unsigned TIMEOUT       = 255;
    localparam int          TBL_MAX       = 2048;
    localparam int          NCYC          = 12000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] prdata = 16'h0000;
    logic        pready = 1'b0;
    logic        convst, psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [15:0] sample_data;
    logic [1:0]  sample_idx;
    logic        sample_valid, frame_done, timeout_err, busy;

    adc_poll_seq #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .CONV_WAIT     (CONV_WAIT),
        .NUM_CH        (NUM_CH),
        .CH_ADDR       (CH_ADDR),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .convst       (convst),
        .paddr        (paddr),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .prdata       (prdata),
        .pready       (pready),
        .sample_data  (sample_data),
        .sample_idx   (sample_idx),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One expected cycle of a frame, offset 0 = the CONVST cycle
    typedef struct packed {
        logic        convst;
        logic        psel;
        logic        penable;
        logic        rdy;
        logic        sv;
        logic        fd;
        logic        to;
        logic [7:0]  paddr;
        logic [1:0]  sidx;
        logic [15:0] sdata;
    } slot_t;

    slot_t tbl [TBL_MAX];
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cyc          = 0;
    int    frame_no     = 0;
    int    t0           = 0;
    int    flen         = 0;
    int    run_start    = 0;
    bit    frame_on     = 1'b0;
    bit    prev_run     = 1'b0;
    bit    terr_m       = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expand one frame into its expected cycle-by-cycle schedule
    task automatic build_frame();
        int          pos;
        int          d;
        bit          tmo;
        logic [15:0] val;
        logic [7:0]  addr;
        logic [31:0] amap;
        amap = CH_ADDR;
        for (int k = 0; k < TBL_MAX; k++) tbl[k] = '0;
        tbl[0].convst = 1'b1;
        pos = CONV_WAIT + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            addr = amap[8*ch +: 8];
            tmo  = 1'b0;
            d    = $urandom_range(0, 6);
            if (frame_no == 0) d = 0;
            else if (frame_no == 1) d = (ch == 1) ? 5 : 0;
            else if (frame_no == 2 && ch == 2) tmo = 1'b1;
            else if ($urandom_range(0, 11) == 0) tmo = 1'b1;
            val = (frame_no == 0) ? 16'(16'hA000 + {8'h00, addr}) : 16'($urandom);
            tbl[pos].psel  = 1'b1;
            tbl[pos].paddr = addr;
            pos++;
            if (tmo) begin
                for (int j = 0; j < TIMEOUT; j++) begin
                    tbl[pos].psel    = 1'b1;
                    tbl[pos].penable = 1'b1;
                    tbl[pos].paddr   = addr;
                    pos++;
                end
            end else begin
                for (int j = 0; j <= d; j++) begin
                    tbl[pos].psel    = 1'b1;
                    tbl[pos].penable = 1'b1;
                    tbl[pos].paddr   = addr;
                    if (j == d) begin
                        tbl[pos].rdy   = 1'b1;
                        tbl[pos].sdata = val;
                    end
                    pos++;
                end
            end
            tbl[pos].sv    = !tmo;
            tbl[pos].sidx  = 2'(ch);
            tbl[pos].sdata = val;
            tbl[pos].fd    = (ch == NUM_CH - 1);
            tbl[pos].to    = tmo;
            pos++;
        end
        flen = pos;
    endtask

    initial begin
        slot_t       cur;
        bit          cur_in;
        bit          rst_c, en_c;
        bit          rst_done, drop_done;
        int          rst_until, drop_until;
        logic [15:0] exp_ctl, obs_ctl;
        rst_done   = 1'b0;
        drop_done  = 1'b0;
        rst_until  = 0;
        drop_until = 0;
        while (cyc < NCYC) begin
            @(posedge clk);
            #1;
            cur_in = frame_on && (cyc >= t0) && (cyc < t0 + flen);
            cur    = cur_in ? tbl[cyc - t0] : '0;

            // Scripted disturbances: one reset during channel-1 access, one
            // enable drop during the conversion wait, then random drops.
            if (!rst_done && frame_no >= 7 && cur_in && cur.penable && cur.paddr == 8'h01) begin
                rst_done  = 1'b1;
                rst_until = cyc + 3;
            end
            if (!drop_done && frame_no >= 4 && cur_in && (cyc - t0) >= 1 && (cyc - t0) <= CONV_WAIT) begin
                drop_done  = 1'b1;
                drop_until = cyc + 150;
            end
            if (frame_no >= 10 && cyc >= drop_until && $urandom_range(0, 399) == 0)
                drop_until = cyc + $urandom_range(1, 300);
            rst_c = (cyc < 3) || (cyc < rst_until);
            en_c  = (cyc >= 3) && (cyc >= drop_until);

            // Reference model update for this cycle
            if (rst_c) begin
                frame_on = 1'b0;
                terr_m   = 1'b0;
                prev_run = 1'b0;
            end else begin
                if (en_c && !prev_run) run_start = cyc;
                prev_run = en_c;
                if (cur.to) terr_m = 1'b1;
                if (!cur_in && en_c && ((cyc - run_start) % SAMPLE_PERIOD) == 0) begin
                    t0 = cyc + 1;
                    build_frame();
                    frame_on = 1'b1;
                    frame_no++;
                end
            end

            rst    = rst_c;
            enable = en_c;
            pready = (!rst_c && cur_in && cur.penable) ? cur.rdy : 1'($urandom);
            prdata = (!rst_c && cur_in && cur.penable && cur.rdy) ? cur.sdata : 16'($urandom);
            #1;

            if (rst_c) begin
                check_val("rst_ctl", 32'({convst, psel, penable, pwrite, busy, sample_valid, frame_done, timeout_err}), 32'd0);
                check_val("rst_data", 32'({paddr, sample_idx, sample_data}), 32'd0);
            end else begin
                exp_ctl = {cur.convst, cur.psel, cur.penable, 1'b0, cur_in, cur.sv, cur.fd, terr_m,
                           (cur.psel ? cur.paddr : 8'h00)};
                obs_ctl = {convst, psel, penable, pwrite, busy, sample_valid, frame_done, timeout_err,
                           (cur.psel ? paddr : 8'h00)};
                check_val("ctl", 32'(obs_ctl), 32'(exp_ctl));
                if (cur.sv)
                    check_val("sample", 32'({sample_idx, sample_data}), 32'({cur.sidx, cur.sdata}));
            end
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
